// File: rtl/tone_sequencer.sv
// tone_sequencer: queued note player that plays each note's tone, then its gap.
// Ports: clock, reset (async low), cmd_wr/cmd_data push, flush; tone, audio_en, busy, level, full, overflow, done.
module tone_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_wr,
  input  logic [31:0]      cmd_data,
  input  logic             flush,
  output logic [3:0]       tone,
  output logic             audio_en,
  output logic             busy,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             overflow,
  output logic             done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [11:0]      ms_q, ms_d;
  logic [7:0]       gap_q, gap_d;
  logic [3:0]       tone_q, tone_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  logic [23:0] mem_q [DEPTH];
  logic [23:0] head;
  logic        tick_wrap, last_ms;
  logic        load, note_end, pop, push_ok;
  logic        unused_hi;

  assign head      = mem_q[rd_ptr_q];
  assign tick_wrap = (tick_q == TICK_LAST);
  assign last_ms   = tick_wrap && (ms_q == 12'd1);
  assign unused_hi = ^cmd_data[31:24];

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    tick_d     = tick_q;
    ms_d       = ms_q;
    gap_d      = gap_q;
    tone_d     = tone_q;
    en_d       = en_q;
    done_d     = 1'b0;
    load       = 1'b0;
    note_end   = 1'b0;
    pop        = 1'b0;
    push_ok    = 1'b0;

    unique case (state_q)
      IDLE: load = (level_q != '0);
      PLAY: begin
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) ms_d = ms_q - 12'd1;
        if (last_ms) begin
          if (gap_q != 8'd0) begin
            state_d = GAP;
            ms_d    = {4'd0, gap_q};
            tick_d  = '0;
            tone_d  = '0;
            en_d    = 1'b0;
          end else begin
            note_end = 1'b1;
          end
        end
      end
      GAP: begin
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) ms_d = ms_q - 12'd1;
        // ms==0 here only on a dur=0/gap=0 pass-through
        if (ms_q == 12'd0 || last_ms) note_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (note_end) begin
      if (level_q != '0) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        tick_d  = '0;
        ms_d    = '0;
        tone_d  = '0;
        en_d    = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (load) begin
      pop    = 1'b1;
      tick_d = '0;
      gap_d  = head[23:16];
      if (head[15:4] != 12'd0) begin
        state_d = PLAY;
        ms_d    = head[15:4];
        tone_d  = head[3:0];
        en_d    = (head[3:0] != 4'd0);
      end else begin
        state_d = GAP;
        ms_d    = {4'd0, head[23:16]};
        tone_d  = '0;
        en_d    = 1'b0;
      end
    end

    push_ok  = cmd_wr && ((level_q != LVL_MAX) || pop);
    if (cmd_wr && !push_ok) overflow_d = 1'b1;
    level_d  = level_q + CNT_W'(push_ok) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    if (flush) begin
      state_d    = IDLE;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      tick_d     = '0;
      ms_d       = '0;
      tone_d     = '0;
      en_d       = 1'b0;
      done_d     = 1'b0;
      push_ok    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tick_q     <= '0;
      ms_q       <= '0;
      gap_q      <= '0;
      tone_q     <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      gap_q      <= gap_d;
      tone_q     <= tone_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= cmd_data[23:0];
  end

  assign tone     = tone_q;
  assign audio_en = en_q;
  assign busy     = (state_q != IDLE);
  assign level    = level_q;
  assign full     = (level_q == LVL_MAX);
  assign overflow = overflow_q;
  assign done     = done_q;
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a queued list of notes through the AudioController without CPU busy-wait timing.
- The CPU writes note commands (tone, duration, gap) into a FIFO through one memory-mapped store.
- The sequencer pops each command, holds the tone for its duration, then silences the speaker for its gap.
- It drives the AudioController tone input and the amplifier enable, and sits on the 50 MHz CPU clock domain.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2)
TICK_DIV, 50000, clock cycles per 1 ms tick (sim uses 10)
CNT_W, 5, width of level output (log2(DEPTH)+1)

Ports:
clock  in  1  system clock (50 MHz CPU clock)
reset  in  1  asynchronous, active-low reset
cmd_wr  in  1  push strobe, one cycle per command
cmd_data  in  32  [3:0] tone, [15:4] duration ms, [23:16] gap ms, [31:24] ignored
flush  in  1  synchronous abort: empty FIFO, silence, go IDLE
tone  out  4  to AudioController tone input
audio_en  out  1  amplifier enable
busy  out  1  high in any state except IDLE
level  out  CNT_W  FIFO occupancy, 0..DEPTH
full  out  1  level==DEPTH
overflow  out  1  sticky; set on a dropped push, cleared by flush
done  out  1  one-cycle pulse when the last queued note's gap ends

Behaviour:
- Reset (reset=0, async):
  - State IDLE; FIFO empty; tick counter and duration counter 0.
  - tone=0, audio_en=0, busy=0, level=0, full=0, overflow=0, done=0.
- FIFO:
  - Push accepted when cmd_wr=1 and (level<DEPTH or a pop occurs the same cycle).
  - Otherwise the push is dropped and overflow is set.
  - Simultaneous push and pop: both occur, level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- States IDLE, PLAY, GAP.
- IDLE:
  - If level>0: pop the head, load tone/dur/gap registers, enter PLAY.
  - A push at edge N is popped at edge N+1; tone is valid after edge N+1.
- PLAY:
  - tone=loaded tone; audio_en=1 iff tone!=0.
  - Lasts exactly dur*TICK_DIV cycles.
  - Tick counter restarts at 0 on entry; ms counter decrements on each tick wrap.
  - dur=0: PLAY is not entered. The pop edge goes directly to GAP with tone=0 and audio_en=0.
- GAP:
  - tone=0, audio_en=0.
  - Lasts exactly gap*TICK_DIV cycles.
  - gap=0: GAP is skipped.
- End of GAP, or end of PLAY when gap=0:
  - If level>0: pop the next entry in the same edge and enter PLAY (back-to-back, no idle cycle).
  - Otherwise enter IDLE and assert done for one cycle.
- flush:
  - Highest priority.
  - On the next edge: FIFO empty, state IDLE, tone=0, audio_en=0, overflow=0.
  - A cmd_wr in the same cycle is discarded and does not set overflow.
  - done is not pulsed.
- busy=1 in PLAY and GAP, including a dur=0/gap=0 pass-through cycle.
- Async reset mid-note silences the outputs immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from cmd_wr or flush to the outputs.
- Counter widths:
  - ms counter is 12 bits.
  - Tick counter is ceil(log2(TICK_DIV)) bits.
  - No truncation for dur=4095.

Test Plan:
- TICK_DIV=10. Push tone=5, dur=3, gap=2 at edge 0:
  - tone=5, audio_en=1 for cycles 1-30.
  - tone=0, audio_en=0 for cycles 31-50.
  - done pulses in cycle 51; busy is 0 afterwards.
- Push three notes (tone 1/2/3, dur=1, gap=0) back-to-back:
  - Tone changes 1->2->3 at cycles 1, 11, 21 with no silent cycle.
  - level reads 0 after the third pop.
- Push DEPTH+1 notes while the first is playing:
  - full=1 at level=16; the 17th push is dropped and overflow=1.
  - A push coincident with a pop at level=16 is accepted and overflow stays 0.
- Edge cases on note fields:
  - tone=0, dur=2 gives audio_en=0 for 20 cycles, then GAP.
  - dur=0, gap=1 gives 10 silent cycles.
  - dur=0, gap=0 pops the next note immediately.
- Assert flush mid-PLAY with cmd_wr in the same cycle:
  - Next cycle: tone=0, audio_en=0, level=0, busy=0, overflow=0, no done pulse.
- Drop reset asynchronously mid-PLAY:
  - tone and audio_en go to 0 before the next clock edge.
  - After reset release, the sequencer idles until a new push arrives.
